// File: rtl/bnn_sequencer.sv
// Sequenced 2-2-1 XNOR network: one shared accumulator walks hidden 0, hidden 1, output; 10 cycles start-to-done.
// No backpressure: start is sampled only while idle, requests during a run are dropped; done is a 1-cycle pulse.
module bnn_sequencer #(
  parameter int WW = 16,
  parameter int AW = 3
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 start,
  input  logic                 x0,
  input  logic                 x1,
  input  logic signed [WW-1:0] b [0:2],
  output logic [AW-1:0]        wt_addr,
  input  logic signed [WW-1:0] wt_data,
  output logic                 busy,
  output logic                 done,
  output logic                 out
);

  // Two guard bits: three WW-bit signed terms can never overflow this width.
  localparam int ACCW = WW + 2;

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, ACT} state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic                   x0_r;
  logic                   x1_r;
  logic signed [WW-1:0]   b_r [0:2];
  logic [1:0]             h;
  logic [1:0]             k;
  logic signed [ACCW-1:0] acc;

  logic signed [WW-1:0]   bias_sel;
  logic                   in_sel;
  logic signed [ACCW-1:0] term;
  logic                   y;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    wt_addr   = '0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_nxt = ACC0;
        end
      end
      ACC0: begin
        wt_addr   = AW'({k, 1'b0});
        state_nxt = ACC1;
      end
      ACC1: begin
        wt_addr   = AW'({k, 1'b1});
        state_nxt = ACT;
      end
      ACT: begin
        wt_addr   = AW'({k, 1'b1});
        state_nxt = (k == 2'd2) ? IDLE : ACC0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The output neuron (k=2) takes the hidden results in place of the network inputs.
  always_comb begin
    bias_sel = b_r[2];
    in_sel   = 1'b0;
    term     = '0;
    case (k)
      2'd0:    bias_sel = b_r[0];
      2'd1:    bias_sel = b_r[1];
      default: bias_sel = b_r[2];
    endcase
    if (state == ACC0) begin
      in_sel = (k == 2'd2) ? h[0] : x0_r;
    end else begin
      in_sel = (k == 2'd2) ? h[1] : x1_r;
    end
    if (in_sel) begin
      term = {{2{wt_data[WW-1]}}, wt_data};
    end
  end

  assign y = ~acc[ACCW-1];

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      x0_r   <= 1'b0;
      x1_r   <= 1'b0;
      b_r[0] <= '0;
      b_r[1] <= '0;
      b_r[2] <= '0;
      h      <= '0;
      k      <= '0;
      acc    <= '0;
      out    <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            x0_r   <= x0;
            x1_r   <= x1;
            b_r[0] <= b[0];
            b_r[1] <= b[1];
            b_r[2] <= b[2];
            k      <= 2'd0;
          end
        end
        ACC0: acc <= {{2{bias_sel[WW-1]}}, bias_sel} + term;
        ACC1: acc <= acc + term;
        ACT: begin
          if (k == 2'd2) begin
            out  <= y;
            done <= 1'b1;
          end else begin
            h[k[0]] <= y;
            k       <= k + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bnn_sequencer.sv
// Directed bench for bnn_sequencer: a cycle-level reference model compared every cycle,
// plus literal expectations for results, latency and the weight-address trace.
module tb_bnn_sequencer;

  logic              Clk = 1'b0;
  logic              Reset_n = 1'b0;
  logic              start = 1'b0;
  logic              x0 = 1'b0;
  logic              x1 = 1'b0;
  logic signed [15:0] b [0:2];
  logic signed [15:0] rom [0:7];
  logic [2:0]        wt_addr;
  logic signed [15:0] wt_data;
  logic              busy;
  logic              done;
  logic              out;

  int checks = 0;
  int failures = 0;

  assign wt_data = rom[wt_addr];

  bnn_sequencer #(.WW(16), .AW(3)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .start(start), .x0(x0), .x1(x1), .b(b),
    .wt_addr(wt_addr), .wt_data(wt_data), .busy(busy), .done(done), .out(out)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: cycle count through an inference and arithmetic network evaluation.
  int   m_cnt = 0;
  int   m_x0 = 0;
  int   m_x1 = 0;
  int   m_b [3] = '{0, 0, 0};
  logic m_out = 1'b0;
  logic m_done = 1'b0;

  function automatic logic neuron(int bias, int i0, int i1, int w0, int w1);
    return (bias + i0 * w0 + i1 * w1) >= 0;
  endfunction

  function automatic logic net_result();
    int h0 = int'(neuron(m_b[0], m_x0, m_x1, int'(rom[0]), int'(rom[1])));
    int h1 = int'(neuron(m_b[1], m_x0, m_x1, int'(rom[2]), int'(rom[3])));
    return neuron(m_b[2], h0, h1, int'(rom[4]), int'(rom[5]));
  endfunction

  // Each neuron takes three cycles: first weight, second weight, then activation on the second address.
  function automatic int exp_addr(int cnt);
    int j;
    int s;
    if (cnt == 0) return 0;
    j = (cnt - 1) / 3;
    s = (cnt - 1) % 3;
    return (s == 0) ? 2 * j : 2 * j + 1;
  endfunction

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      m_cnt  = 0;
      m_out  = 1'b0;
      m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_cnt == 0) begin
        if (start === 1'b1) begin
          m_x0 = int'(x0);
          m_x1 = int'(x1);
          for (int i = 0; i < 3; i++) m_b[i] = int'(b[i]);
          m_cnt = 1;
        end
      end else if (m_cnt < 9) begin
        m_cnt++;
      end else begin
        m_cnt  = 0;
        m_out  = net_result();
        m_done = 1'b1;
      end
    end
  end

  initial begin
    forever begin
      @(posedge Clk);
      #1;
      chk("model_busy", int'(busy), int'(m_cnt != 0));
      chk("model_done", int'(done), int'(m_done));
      chk("model_out", int'(out), int'(m_out));
      chk("model_addr", int'(wt_addr), exp_addr(m_cnt));
    end
  end

  task automatic set_rom(input int r0, input int r1, input int r2, input int r3, input int r4, input int r5);
    rom[0] = 16'(r0); rom[1] = 16'(r1); rom[2] = 16'(r2);
    rom[3] = 16'(r3); rom[4] = 16'(r4); rom[5] = 16'(r5);
    rom[6] = '0;      rom[7] = '0;
  endtask

  task automatic set_b(input int b0, input int b1, input int b2);
    b[0] = 16'(b0); b[1] = 16'(b1); b[2] = 16'(b2);
  endtask

  // Launches one inference; optional extra start pulses at cycles pa/pb of the run.
  task automatic run_one(input logic a, input logic c, input logic e, input string name,
                         input int pa, input int pb);
    int lat;
    int tr [10];
    int exp_tr [10];
    logic [29:0] act_p;
    logic [29:0] exp_p;
    exp_tr = '{0, 1, 1, 2, 3, 3, 4, 5, 5, 0};
    for (int i = 0; i < 10; i++) tr[i] = 7;
    @(negedge Clk);
    x0 = a; x1 = c; start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    x0 = ~a; x1 = ~c;
    lat = 99;
    for (int n = 1; n <= 20; n++) begin
      if (n <= 10) tr[n-1] = int'(wt_addr);
      if (done === 1'b1) begin
        lat = n;
        break;
      end
      start = (n == pa || n == pb);
      @(negedge Clk);
    end
    start = 1'b0;
    act_p = '0;
    exp_p = '0;
    for (int i = 0; i < 10; i++) begin
      act_p[3*i +: 3] = 3'(tr[i]);
      exp_p[3*i +: 3] = 3'(exp_tr[i]);
    end
    chk({name, "_latency"}, lat, 10);
    chk({name, "_addr_trace"}, int'(act_p), int'(exp_p));
    chk({name, "_out"}, int'(out), int'(e));
  endtask

  initial begin
    int ndone;
    set_rom(100, 100, -100, -100, 100, 100);
    set_b(-150, 50, -50);
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      chk("idle_out", int'(out), 0);
      chk("idle_done", int'(done), 0);
      chk("idle_busy", int'(busy), 0);
      chk("idle_addr", int'(wt_addr), 0);
    end

    run_one(1'b0, 1'b0, 1'b1, "xnor00", 0, 0);
    run_one(1'b0, 1'b1, 1'b0, "xnor01", 0, 0);
    run_one(1'b1, 1'b0, 1'b0, "xnor10", 0, 0);
    run_one(1'b1, 1'b1, 1'b1, "xnor11", 0, 0);

    // acc is exactly zero in hidden 0 and in the output neuron; both must fire.
    set_rom(100, 100, -100, -100, 100, 0);
    set_b(-100, 50, -100);
    run_one(1'b1, 1'b0, 1'b1, "tie", 0, 0);

    set_rom(32767, 32767, 32767, 32767, 32767, 32767);
    set_b(32767, 32767, 32767);
    run_one(1'b1, 1'b1, 1'b1, "overflow", 0, 0);

    set_rom(100, 100, -100, -100, 100, 100);
    set_b(-150, 50, -50);

    // Abort a run with reset while out still holds 1 from the previous result.
    @(negedge Clk);
    x0 = 1'b0; x1 = 1'b0; start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    repeat (4) @(negedge Clk);
    Reset_n = 1'b0;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_out", int'(out), 0);
    chk("abort_addr", int'(wt_addr), 0);
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge Clk);
      if (done === 1'b1) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    run_one(1'b1, 1'b1, 1'b1, "after_reset", 0, 0);

    run_one(1'b0, 1'b1, 1'b0, "ignore", 3, 9);
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge Clk);
      if (done === 1'b1) ndone++;
    end
    chk("ignore_extra_done", ndone, 0);
    chk("ignore_busy", int'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
